apb_cmd_arbiter: RTL and testbench

Two-requester arbiter and APB3/APB4 master sequencer for the register bus. It sits between command sources (the UART command parser and a second on-chip source such as a local init/test engine) and the single APB register bus. It latches each requester's single-cycle command, grants the bus round-robin, runs the APB setup/access phases with a PREADY timeout, and returns a per-requester done pulse, read data and error flag.

---
 rtl/apb_cmd_arbiter_pkg.sv | 18 +
 rtl/apb_cmd_req_slot.sv | 60 ++++++
 rtl/apb_cmd_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_apb_cmd_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_arbiter_pkg.sv
// Shared types and constants for the APB command arbiter.
package apb_cmd_arbiter_pkg;

    // Bus sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Requester index (two requesters)
    typedef logic req_idx_t;

    // Default cap on ACCESS-phase cycles before forced completion
    localparam int unsigned DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/apb_cmd_req_slot.sv
// Per-requester pending flag and single-entry command capture register.
module apb_cmd_req_slot
    import apb_cmd_arbiter_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32,
    parameter int unsigned SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cmd_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic [SW-1:0] i_strb,
    input  logic          i_clr,
    output logic          o_pend,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    output logic [SW-1:0] o_strb
);

    logic          r_pend;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_strb;
    logic          w_take;

    // A new command is accepted when idle, or when the current one is being
    // retired this very cycle (set beats clear).
    assign w_take = i_cmd_en && (!r_pend || i_clr);

    // Pending flag and command capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_take) begin
            r_pend  <= 1'b1;
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_strb  <= i_strb;
        end else if (i_clr) begin
            r_pend  <= 1'b0;
        end
    end

    assign o_pend  = r_pend;
    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_strb  = r_strb;

endmodule

// File: rtl/apb_cmd_arbiter.sv
// Two-requester round-robin arbiter and APB master sequencer with
// PREADY timeout and per-requester completion/response registers.
module apb_cmd_arbiter
    import apb_cmd_arbiter_pkg::*;
#(
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 32,
    parameter int unsigned SW          = 4,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_cmd_en,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [SW-1:0] r0_strb,
    output logic          r0_cmd_done,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_err,
    input  logic          r1_cmd_en,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    input  logic [SW-1:0] r1_strb,
    output logic          r1_cmd_done,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_err,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    output logic [SW-1:0] pstrb,
    input  logic          pready,
    input  logic          pslverr,
    input  logic [DW-1:0] prdata
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    req_idx_t          r_gnt;
    req_idx_t          r_prio;
    req_idx_t          w_sel;
    logic [TCNT_W-1:0] r_tcnt;
    logic              w_tmo;
    logic              w_fin;
    logic              w_grant;

    logic              w_pend0, w_we0, w_pend1, w_we1;
    logic [AW-1:0]     w_addr0, w_addr1;
    logic [DW-1:0]     w_wdata0, w_wdata1;
    logic [SW-1:0]     w_strb0, w_strb1;

    logic              w_sel_we;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic [SW-1:0]     w_sel_strb;

    logic              r_pwrite;
    logic [AW-1:0]     r_paddr;
    logic [DW-1:0]     r_pwdata;
    logic [SW-1:0]     r_pstrb;
    logic              r_err0, r_err1;
    logic [DW-1:0]     r_rdata0, r_rdata1;

    logic              w_psel, w_penable, w_done0, w_done1;

    apb_cmd_req_slot #(.AW(AW), .DW(DW), .SW(SW)) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cmd_en (r0_cmd_en),
        .i_we     (r0_we),
        .i_addr   (r0_addr),
        .i_wdata  (r0_wdata),
        .i_strb   (r0_strb),
        .i_clr    (w_done0),
        .o_pend   (w_pend0),
        .o_we     (w_we0),
        .o_addr   (w_addr0),
        .o_wdata  (w_wdata0),
        .o_strb   (w_strb0)
    );

    apb_cmd_req_slot #(.AW(AW), .DW(DW), .SW(SW)) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cmd_en (r1_cmd_en),
        .i_we     (r1_we),
        .i_addr   (r1_addr),
        .i_wdata  (r1_wdata),
        .i_strb   (r1_strb),
        .i_clr    (w_done1),
        .o_pend   (w_pend1),
        .o_we     (w_we1),
        .o_addr   (w_addr1),
        .o_wdata  (w_wdata1),
        .o_strb   (w_strb1)
    );

    // Timeout fires once the ACCESS counter (0 on entry) reaches the limit
    assign w_tmo   = (r_tcnt == TCNT_W'(TIMEOUT_CYC));
    assign w_fin   = (r_state == ST_ACCESS) && (pready || w_tmo);
    assign w_grant = (r_state == ST_IDLE) && (w_pend0 || w_pend1);

    // Requester selection: round-robin priority only matters when both wait
    always_comb begin
        w_sel       = (w_pend0 && w_pend1) ? r_prio : w_pend1;
        w_sel_we    = w_sel ? w_we1    : w_we0;
        w_sel_addr  = w_sel ? w_addr1  : w_addr0;
        w_sel_wdata = w_sel ? w_wdata1 : w_wdata0;
        w_sel_strb  = w_sel ? w_strb1  : w_strb0;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_pend0 || w_pend1) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (pready || w_tmo) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: APB phase control and completion pulses
    always_comb begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        w_done0   = 1'b0;
        w_done1   = 1'b0;
        unique case (r_state)
            ST_SETUP:  w_psel = 1'b1;
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            ST_DONE: begin
                w_done0 = ~r_gnt;
                w_done1 = r_gnt;
            end
            default: ;
        endcase
    end

    // Grant capture and APB address/data registers; loaded on grant so they
    // stay stable through SETUP/ACCESS and hold afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_grant) begin
            r_gnt    <= w_sel;
            r_pwrite <= w_sel_we;
            r_paddr  <= w_sel_addr;
            r_pwdata <= w_sel_we ? w_sel_wdata : '0;
            r_pstrb  <= w_sel_we ? w_sel_strb  : '0;
        end
    end

    // Round-robin pointer: prefer the other requester after each completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_prio <= ~r_gnt;
        end
    end

    // ACCESS-phase cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (r_state != ST_ACCESS) begin
            r_tcnt <= '0;
        end else if (!w_tmo) begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end
    end

    // Response capture on leaving ACCESS so it is valid alongside the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_fin) begin
            if (!r_gnt) begin
                r_err0 <= pready ? pslverr : 1'b1;
                if (!r_pwrite) r_rdata0 <= pready ? prdata : '0;
            end else begin
                r_err1 <= pready ? pslverr : 1'b1;
                if (!r_pwrite) r_rdata1 <= pready ? prdata : '0;
            end
        end
    end

    assign psel        = w_psel;
    assign penable     = w_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign r0_cmd_done = w_done0;
    assign r1_cmd_done = w_done1;
    assign r0_rdata    = r_rdata0;
    assign r1_rdata    = r_rdata1;
    assign r0_err      = r_err0;
    assign r1_err      = r_err1;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Self-checking bench for apb_cmd_arbiter (TIMEOUT_CYC = 8).
module tb_apb_cmd_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_cmd_en = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic [SW-1:0] r0_strb = '0;
    logic          r0_cmd_done, r0_err;
    logic [DW-1:0] r0_rdata;
    logic          r1_cmd_en = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic [SW-1:0] r1_strb = '0;
    logic          r1_cmd_done, r1_err;
    logic [DW-1:0] r1_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] prdata;

    int            cfg_waits = 0;
    logic          cfg_err = 1'b0;
    logic [DW-1:0] cfg_prdata = '0;

    assign pslverr = cfg_err;
    assign prdata  = cfg_prdata;

    always #5 clk = ~clk;

    apb_cmd_arbiter #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_cmd_en(r0_cmd_en), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_strb(r0_strb), .r0_cmd_done(r0_cmd_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_cmd_en(r1_cmd_en), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_strb(r1_strb), .r1_cmd_done(r1_cmd_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        bit            err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_rdata [2];

    typedef struct {
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            waits;
        bit            slverr;
        logic [DW-1:0] prd;
        int            lat;
    } vec_t;

    vec_t vt[7];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void push_exp(bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] wd,
                                     logic [SW-1:0] st, int waits, bit se, logic [DW-1:0] prd);
        exp_t e;
        bit   to;
        to      = (waits > int'(TMO));
        e.req   = req;
        e.we    = we;
        e.addr  = a;
        e.wdata = we ? wd : '0;
        e.strb  = we ? st : '0;
        e.err   = to ? 1'b1 : se;
        if (we) e.rdata = model_rdata[req];
        else    e.rdata = to ? '0 : prd;
        model_rdata[req] = e.rdata;
        sb.push_back(e);
    endfunction

    task automatic set_cmd(bit req, bit en, bit we, logic [AW-1:0] a, logic [DW-1:0] wd,
                           logic [SW-1:0] st);
        if (req) begin
            r1_cmd_en = en; r1_we = we; r1_addr = a; r1_wdata = wd; r1_strb = st;
        end else begin
            r0_cmd_en = en; r0_we = we; r0_addr = a; r0_wdata = wd; r0_strb = st;
        end
    endtask

    task automatic wait_drain(int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // APB slave: raises pready on access cycle number cfg_waits (0-based)
    initial begin
        int acc;
        acc    = 0;
        pready = 1'b0;
        forever begin
            @(negedge clk);
            if (psel && penable) begin
                pready = (acc == cfg_waits);
                acc++;
            end else begin
                pready = 1'b0;
                acc    = 0;
            end
        end
    end

    // Monitor: SETUP fields against the next expected transfer, completions
    // against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (psel && !penable) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL setup_unexpected actual=%0h required=none", paddr);
                    end else begin
                        chk("setup_paddr",  paddr,  sb[0].addr);
                        chk("setup_pwrite", pwrite, sb[0].we);
                        chk("setup_pwdata", pwdata, sb[0].wdata);
                        chk("setup_pstrb",  pstrb,  sb[0].strb);
                    end
                end
                if (r0_cmd_done || r1_cmd_done) begin
                    chk("done_onehot", r0_cmd_done & r1_cmd_done, 0);
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done_unexpected actual=%0b%0b required=00", r1_cmd_done, r0_cmd_done);
                    end else begin
                        e = sb.pop_front();
                        chk("done_req", r1_cmd_done, e.req);
                        if (e.req) begin
                            chk("r1_err",   r1_err,   e.err);
                            chk("r1_rdata", r1_rdata, e.rdata);
                        end else begin
                            chk("r0_err",   r0_err,   e.err);
                            chk("r0_rdata", r0_rdata, e.rdata);
                        end
                    end
                end
            end
        end
    end

    // One command with cycle-accurate phase and latency checks
    task automatic timed(bit req, bit we, logic [AW-1:0] a, logic [DW-1:0] wd, logic [SW-1:0] st,
                         int waits, bit se, logic [DW-1:0] prd, int lat);
        int off = -1;
        cfg_waits = waits; cfg_err = se; cfg_prdata = prd;
        @(posedge clk); #1;
        set_cmd(req, 1'b1, we, a, wd, st);
        push_exp(req, we, a, wd, st, waits, se, prd);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n == 1) chk("t1_idle",   {psel, penable}, 2'b00);
            if (n == 2) chk("t2_setup",  {psel, penable}, 2'b10);
            if (n == 3) chk("t3_access", {psel, penable}, 2'b11);
            if (off < 0 && (req ? r1_cmd_done : r0_cmd_done)) off = n;
            if (n == 0) begin
                @(posedge clk); #1;
                set_cmd(req, 1'b0, 1'b0, '0, '0, '0);
            end
            if (off >= 0) break;
        end
        chk("done_latency", off, lat);
    endtask

    // Both requesters in the same cycle; first is the expected winner
    task automatic pair(bit first);
        int gap  = -1;
        bit seen = 0;
        cfg_waits = 0; cfg_err = 1'b0; cfg_prdata = 32'h0BEE_F00D;
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b1, 1'b1, 16'h0100, 32'h1111_2222, 4'hF);
        set_cmd(1'b1, 1'b1, 1'b0, 16'h0200, '0, '0);
        if (!first) begin
            push_exp(1'b0, 1'b1, 16'h0100, 32'h1111_2222, 4'hF, 0, 1'b0, cfg_prdata);
            push_exp(1'b1, 1'b0, 16'h0200, '0, '0, 0, 1'b0, cfg_prdata);
        end else begin
            push_exp(1'b1, 1'b0, 16'h0200, '0, '0, 0, 1'b0, cfg_prdata);
            push_exp(1'b0, 1'b1, 16'h0100, 32'h1111_2222, 4'hF, 0, 1'b0, cfg_prdata);
        end
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!seen && (first ? r1_cmd_done : r0_cmd_done)) begin
                seen = 1;
                gap  = 0;
            end else if (seen) begin
                gap++;
                if (psel && !penable) break;
            end
        end
        chk("pair_gap", gap, 2);
        wait_drain(40);
    endtask

    initial begin
        bit seen;
        model_rdata[0] = '0;
        model_rdata[1] = '0;

        vt[0] = '{1'b0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF,  0, 1'b0, 32'h0,         4};
        vt[1] = '{1'b1, 1'b0, 16'h0020, 32'h0,         4'h0,  3, 1'b0, 32'h1234_5678, 7};
        vt[2] = '{1'b0, 1'b0, 16'h0030, 32'h0,         4'h0, 20, 1'b0, 32'hFFFF_FFFF, 12};
        vt[3] = '{1'b1, 1'b1, 16'h0024, 32'h0BAD_F00D, 4'h3,  1, 1'b1, 32'h0,         5};
        vt[4] = '{1'b1, 1'b0, 16'h0028, 32'h0,         4'h0,  0, 1'b1, 32'hA5A5_A5A5, 4};
        vt[5] = '{1'b0, 1'b0, 16'h0034, 32'h0,         4'h0,  8, 1'b0, 32'h8765_4321, 12};
        vt[6] = '{1'b0, 1'b1, 16'h0038, 32'h0000_0001, 4'hF,  0, 1'b1, 32'h0,         4};

        #12;
        chk("rst_bus",  {psel, penable, pwrite, paddr, pwdata, pstrb, r0_cmd_done, r1_cmd_done}, 0);
        chk("rst_resp", {r0_err, r1_err, r0_rdata, r1_rdata}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pair(1'b0);
        pair(1'b0);

        for (int i = 0; i < 7; i++) begin
            timed(vt[i].req, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb,
                  vt[i].waits, vt[i].slverr, vt[i].prd, vt[i].lat);
        end
        wait_drain(20);

        pair(1'b1);

        // Duplicate r0 command while still waiting behind r1 is dropped
        cfg_waits = 5; cfg_err = 1'b0; cfg_prdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        set_cmd(1'b1, 1'b1, 1'b0, 16'h0050, '0, '0);
        push_exp(1'b1, 1'b0, 16'h0050, '0, '0, 5, 1'b0, cfg_prdata);
        @(posedge clk); #1;
        set_cmd(1'b1, 1'b0, 1'b0, '0, '0, '0);
        set_cmd(1'b0, 1'b1, 1'b1, 16'h0040, 32'hCAFE_0001, 4'hF);
        push_exp(1'b0, 1'b1, 16'h0040, 32'hCAFE_0001, 4'hF, 5, 1'b0, cfg_prdata);
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b1, 1'b1, 16'h0044, 32'hBAD0_0002, 4'h1);
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wait_drain(60);

        // New command in the same cycle as that requester's done pulse is kept
        cfg_waits = 0; cfg_err = 1'b0; cfg_prdata = 32'h6464_0064;
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b1, 1'b1, 16'h0060, 32'h0000_6060, 4'hC);
        push_exp(1'b0, 1'b1, 16'h0060, 32'h0000_6060, 4'hC, 0, 1'b0, cfg_prdata);
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (r0_cmd_done) seen = 1;
        end
        chk("setwin_done_seen", seen, 1);
        set_cmd(1'b0, 1'b1, 1'b0, 16'h0064, '0, '0);
        push_exp(1'b0, 1'b0, 16'h0064, '0, '0, 0, 1'b0, cfg_prdata);
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wait_drain(30);

        // Reset in the middle of an ACCESS phase
        cfg_waits = 50; cfg_err = 1'b0; cfg_prdata = 32'h7777_7777;
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b1, 1'b0, 16'h0070, '0, '0);
        push_exp(1'b0, 1'b0, 16'h0070, '0, '0, 50, 1'b0, cfg_prdata);
        @(posedge clk); #1;
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (psel && penable) seen = 1;
        end
        chk("rst_access_seen", seen, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_bus",  {psel, penable, pwrite, paddr, pwdata, pstrb, r0_cmd_done, r1_cmd_done}, 0);
        chk("rstmid_resp", {r0_err, r1_err, r0_rdata, r1_rdata}, 0);
        sb.delete();
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_nodone", {r0_cmd_done, r1_cmd_done, psel}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {psel, r0_cmd_done, r1_cmd_done}, 0);
        timed(1'b1, 1'b0, 16'h0080, '0, '0, 1, 1'b0, 32'h0808_0808, 5);
        wait_drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
